// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the hazard scoreboard: Tuse/Tnew codes, default
// mult/div latencies and the latency-counter width helper.
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    TUSE_D = 2'd0,
    TUSE_E = 2'd1,
    TUSE_M = 2'd2
  } tuse_e;

  typedef enum logic [1:0] {
    TNEW_NONE = 2'd0,
    TNEW_ALU  = 2'd1,
    TNEW_LOAD = 2'd2
  } tnew_e;

  localparam logic [1:0] TNEW_MFC0 = 2'd2;

  localparam int DEF_MULT_LAT = 5;
  localparam int DEF_DIV_LAT  = 10;

  // Enough bits to hold the longer of the two unit latencies.
  function automatic int md_cnt_width(int mult_lat, int div_lat);
    int m;
    m = (mult_lat > div_lat) ? mult_lat : div_lat;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_md_latency_counter.sv
// Mult/div busy tracker: loads the operation latency on start and counts
// down to zero; busy while the count is non-zero.
module md_latency_counter
  import hazard_scoreboard_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic div_i,
  output logic busy_o
);

  localparam int W = md_cnt_width(MULT_LAT, DIV_LAT);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // A new start overrides whatever residual count is left.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = div_i ? W'(DIV_LAT) : W'(MULT_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew stall unit: shift-register scoreboard of in-flight GPR producers
// (E..W) with youngest-match RAW detection, plus a mult/div busy interlock.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int TW         = 2,
  parameter int PIPE_DEPTH = 3,
  parameter int MULT_LAT   = DEF_MULT_LAT,
  parameter int DIV_LAT    = DEF_DIV_LAT,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic              d_rs_use,
  input  logic              d_rt_use,
  input  logic [TW-1:0]     d_rs_tuse,
  input  logic [TW-1:0]     d_rt_tuse,
  input  logic              d_wen,
  input  logic [REG_AW-1:0] d_wreg,
  input  logic [TW-1:0]     d_tnew,
  input  logic              d_md_use,
  input  logic              d_md_start,
  input  logic              d_md_div,
  input  logic              flush,
  output logic              stall,
  output logic              md_busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Index 0 is the E stage (youngest); higher indices are older.
  logic [PIPE_DEPTH-1:0]             valid_q, valid_d;
  logic [PIPE_DEPTH-1:0][REG_AW-1:0] wreg_q,  wreg_d;
  logic [PIPE_DEPTH-1:0][TW-1:0]     tnew_q,  tnew_d;
  logic [CNT_W-1:0]                  stall_cnt_q, stall_cnt_d;

  logic              issue;
  logic              rs_hit, rt_hit;
  logic [TW-1:0]     rs_tnew, rt_tnew;
  logic              rs_haz, rt_haz, md_haz;

  assign issue = !stall && !flush;

  for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_e
      // Writes to reg 0 never enter the scoreboard.
      assign valid_d[g] = issue && d_wen && (d_wreg != '0);
      assign wreg_d[g]  = d_wreg;
      assign tnew_d[g]  = d_tnew;
    end else begin : g_shift
      assign valid_d[g] = valid_q[g-1] && !flush;
      assign wreg_d[g]  = wreg_q[g-1];
      assign tnew_d[g]  = (tnew_q[g-1] == '0) ? '0 : tnew_q[g-1] - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= '0;
      wreg_q      <= '0;
      tnew_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      wreg_q      <= wreg_d;
      tnew_q      <= tnew_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Scan oldest to youngest so the youngest matching producer wins,
  // mirroring which value the forwarding network would select.
  always_comb begin
    rs_hit  = 1'b0;
    rt_hit  = 1'b0;
    rs_tnew = '0;
    rt_tnew = '0;
    for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && (wreg_q[i] == d_rs)) begin
        rs_hit  = 1'b1;
        rs_tnew = tnew_q[i];
      end
      if (valid_q[i] && (wreg_q[i] == d_rt)) begin
        rt_hit  = 1'b1;
        rt_tnew = tnew_q[i];
      end
    end
  end

  assign rs_haz = d_rs_use && (d_rs != '0) && rs_hit && (rs_tnew > d_rs_tuse);
  assign rt_haz = d_rt_use && (d_rt != '0) && rt_hit && (rt_tnew > d_rt_tuse);
  assign md_haz = d_md_use && md_busy;
  assign stall  = rs_haz || rt_haz || md_haz;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;

  md_latency_counter #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_cnt (
    .clk     (clk),
    .reset   (reset),
    .start_i (issue && d_md_start),
    .div_i   (d_md_div),
    .busy_o  (md_busy)
  );

endmodule
